// File: rtl/vip_featuremap_pack3_writer_if.sv
// Stream-in / FIFO-out bundle for the 3-channel pixel packer.
// The slave side is the packer. The master side is its environment, which owns the stream source and the FIFO.
interface vip_featuremap_pack3_writer_if #(
  parameter int DWIDTH = 32
);
  logic [DWIDTH-1:0]   s_data;
  logic                s_valid;
  logic                s_ready;
  logic [3*DWIDTH-1:0] ff_wdata;
  logic                ff_wrreq;
  logic                ff_full;

  modport master (output s_data, s_valid, ff_full, input s_ready, ff_wdata, ff_wrreq);
  modport slave  (input s_data, s_valid, ff_full, output s_ready, ff_wdata, ff_wrreq);
endinterface

// File: rtl/vip_featuremap_pack3_writer.sv
// Packs three consecutive channel words into one pixel and writes it to the conv2d input FIFO.
// Each frame holds NPIX pixels and produces a single done pulse at its end.
module vip_featuremap_pack3_writer #(
  parameter int DWIDTH = 32,
  parameter int NPIX   = 12544
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  vip_featuremap_pack3_writer_if.slave bus,
  output logic                        busy,
  output logic                        done,
  output logic [13:0]                 pix_count
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] PUSH    = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  localparam logic [13:0] LAST_PIX = 14'(NPIX - 1);

  logic [1:0]          state;
  logic [1:0]          chan;
  logic [3*DWIDTH-1:0] wdata;
  logic                accept;
  logic                write;

  assign accept = (state == COLLECT) && bus.s_valid;
  // The write strobe is combinational on ff_full, so a full FIFO never sees a write.
  assign write  = (state == PUSH) && !bus.ff_full;

  assign bus.s_ready  = (state == COLLECT);
  assign bus.ff_wrreq = write;
  assign bus.ff_wdata = wdata;
  assign busy         = (state == COLLECT) || (state == PUSH);
  assign done         = (state == DONE);

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the pixel register is reset too, so ff_wdata reads zero while reset is asserted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      chan      <= 2'd0;
      wdata     <= '0;
      pix_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pix_count <= '0;
            chan      <= 2'd0;
            state     <= COLLECT;
          end
        end
        COLLECT: begin
          if (accept) begin
            case (chan)
              2'd0:    wdata[DWIDTH-1:0]          <= bus.s_data;
              2'd1:    wdata[2*DWIDTH-1:DWIDTH]   <= bus.s_data;
              default: wdata[3*DWIDTH-1:2*DWIDTH] <= bus.s_data;
            endcase
            if (chan == 2'd2) begin
              chan  <= 2'd0;
              state <= PUSH;
            end else begin
              chan <= chan + 2'd1;
            end
          end
        end
        PUSH: begin
          // Stalls here with wdata untouched until the FIFO has room.
          if (write) begin
            pix_count <= pix_count + 14'd1;
            state     <= (pix_count == LAST_PIX) ? DONE : COLLECT;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vip_featuremap_pack3_writer.sv
// Directed and randomized checks of the pixel packer against a word-list reference model.
// One instance uses a 4-pixel frame and the other uses the full 112x112 frame.
module tb_vip_featuremap_pack3_writer;

  localparam int DW = 32;

  logic        clock = 1'b0;
  logic        rst_a, rst_b, start_a, start_b;
  logic        busy_a, done_a, busy_b, done_b;
  logic [13:0] pc_a, pc_b;

  always #5 clock = ~clock;

  vip_featuremap_pack3_writer_if #(.DWIDTH(DW)) a ();
  vip_featuremap_pack3_writer_if #(.DWIDTH(DW)) b ();

  vip_featuremap_pack3_writer #(.DWIDTH(DW), .NPIX(4)) dut_a (
    .clock(clock), .reset(rst_a), .start(start_a), .bus(a.slave),
    .busy(busy_a), .done(done_a), .pix_count(pc_a)
  );

  vip_featuremap_pack3_writer #(.DWIDTH(DW)) dut_b (
    .clock(clock), .reset(rst_b), .start(start_b), .bus(b.slave),
    .busy(busy_b), .done(done_b), .pix_count(pc_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Stimulus and observation state for the small instance
  logic [31:0]   words [12];
  logic [31:0]   tx_q [$];
  logic [3*DW-1:0] got_q [$];
  logic [3*DW-1:0] prev_wdata;
  int cyc, first_acc, done_cyc, done_cnt, n_acc;
  int gap_n, gap_left, full_left;
  bit start_req, mid_start_arm, prev_stall;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock of the small instance: sample at negedge, drive just after posedge
  task automatic step_a();
    bit stall;
    @(negedge clock);
    cyc++;
    if (a.s_valid && a.s_ready) begin
      if (first_acc < 0) first_acc = cyc;
      void'(tx_q.pop_front());
      n_acc++;
      gap_left = gap_n;
    end
    stall = busy_a && !a.s_ready && a.ff_full;
    if (a.ff_wrreq) begin
      if (prev_stall) check("wdata_after_stall", a.ff_wdata, prev_wdata);
      got_q.push_back(a.ff_wdata);
    end
    if (stall) begin
      check("wrreq_while_full", a.ff_wrreq, 0);
      if (prev_stall) check("wdata_stable_in_stall", a.ff_wdata, prev_wdata);
      prev_wdata = a.ff_wdata;
      if (full_left > 0) full_left--;
    end
    prev_stall = stall;
    if (done_a) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (mid_start_arm && got_q.size() == 2) begin
      start_req     = 1'b1;
      mid_start_arm = 1'b0;
    end
    @(posedge clock);
    #1;
    start_a   = start_req;
    start_req = 1'b0;
    if (gap_left > 0) begin
      a.s_valid = 1'b0;
      gap_left--;
    end else begin
      a.s_valid = (tx_q.size() > 0);
    end
    a.s_data  = (tx_q.size() > 0) ? tx_q[0] : '0;
    a.ff_full = (full_left > 0);
  endtask

  task automatic start_frame(input int gap, input int full_cycles);
    got_q.delete();
    tx_q.delete();
    foreach (words[i]) tx_q.push_back(words[i]);
    done_cnt   = 0;
    first_acc  = -1;
    n_acc      = 0;
    gap_n      = gap;
    gap_left   = 0;
    full_left  = full_cycles;
    prev_stall = 1'b0;
    start_req  = 1'b1;
  endtask

  task automatic run_to_done(input string tag);
    int t = 0;
    while (done_cnt == 0 && t < 300) begin
      step_a();
      t++;
    end
    check($sformatf("%s_done_timeout", tag), (t < 300), 1);
    repeat (4) step_a();
  endtask

  // Reference: pixel k carries words 3k, 3k+1, 3k+2 with channel 0 in the low bits
  task automatic check_frame(input string tag);
    logic [3*DW-1:0] exp;
    check($sformatf("%s_writes", tag), got_q.size(), 4);
    for (int k = 0; k < 4; k++) begin
      exp = {words[3*k+2], words[3*k+1], words[3*k]};
      if (k < got_q.size()) check($sformatf("%s_pix%0d", tag, k), got_q[k], exp);
    end
    check($sformatf("%s_pix_count", tag), pc_a, 4);
    check($sformatf("%s_done_pulses", tag), done_cnt, 1);
    check($sformatf("%s_busy_idle", tag), busy_a, 0);
  endtask

  task automatic check_reset_a(input string tag);
    check($sformatf("%s_s_ready", tag), a.s_ready, 0);
    check($sformatf("%s_wrreq", tag), a.ff_wrreq, 0);
    check($sformatf("%s_busy", tag), busy_a, 0);
    check($sformatf("%s_done", tag), done_a, 0);
    check($sformatf("%s_pix_count", tag), pc_a, 0);
    check($sformatf("%s_wdata", tag), a.ff_wdata, 0);
  endtask

  initial begin
    logic [31:0] cur;
    logic [31:0] w0, w1, w2;
    logic [31:0] acc_q [$];
    int writes_b, done_cnt_b, bad_b, t;
    logic [3*DW-1:0] exp_b;

    rst_a = 1'b0; rst_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
    a.s_valid = 1'b0; a.s_data = '0; a.ff_full = 1'b0;
    b.s_valid = 1'b0; b.s_data = '0; b.ff_full = 1'b0;
    cyc = 0; start_req = 1'b0; mid_start_arm = 1'b0; prev_stall = 1'b0;
    gap_n = 0; gap_left = 0; full_left = 0; done_cnt = 0; first_acc = -1;
    #12;
    check_reset_a("por");
    check("por_b_pix_count", pc_b, 0);
    check("por_b_busy", busy_b, 0);
    @(posedge clock);
    #1;
    rst_a = 1'b1; rst_b = 1'b1;

    for (int i = 0; i < 12; i++) words[i] = 32'(i + 1);

    // Continuous stream, FIFO never full
    start_frame(0, 0);
    run_to_done("basic");
    check_frame("basic");
    check("basic_done_latency", done_cyc - first_acc, 16);

    // FIFO full for five cycles during the first push
    start_frame(0, 5);
    t = 0;
    while (got_q.size() == 0 && t < 100) begin
      step_a();
      t++;
    end
    step_a();
    check("full_stall_pix_count", pc_a, 1);
    check("full_stall_cycles_consumed", full_left, 0);
    run_to_done("full");
    check_frame("full");

    // Two idle cycles between every word
    start_frame(2, 0);
    run_to_done("gaps");
    check_frame("gaps");

    // Start pulsed mid-frame after the second pixel must be ignored
    start_frame(0, 0);
    mid_start_arm = 1'b1;
    run_to_done("midstart");
    check_frame("midstart");

    // Reset after seven accepted words aborts the frame
    start_frame(0, 0);
    t = 0;
    while (n_acc < 7 && t < 100) begin
      step_a();
      t++;
    end
    check("abort_written_before_reset", got_q.size(), 2);
    rst_a = 1'b0;
    #1;
    check_reset_a("midrst");
    @(posedge clock);
    @(posedge clock);
    #1;
    rst_a = 1'b1;
    got_q.delete();
    repeat (6) step_a();
    check("abort_no_writes", got_q.size(), 0);
    check("abort_no_accepts", tx_q.size(), 5);
    for (int i = 0; i < 12; i++) words[i] = $urandom;
    start_frame(0, 0);
    run_to_done("rearm");
    check_frame("rearm");

    // Full-size frame with random valid and full
    writes_b = 0; done_cnt_b = 0; bad_b = 0;
    cur = $urandom;
    @(posedge clock);
    #1;
    start_b = 1'b1;
    @(posedge clock);
    #1;
    start_b = 1'b0;
    t = 0;
    while (done_cnt_b == 0 && t < 85000) begin
      @(negedge clock);
      t++;
      if (b.s_valid && b.s_ready) begin
        acc_q.push_back(cur);
        cur = $urandom;
      end
      if (b.ff_wrreq) begin
        writes_b++;
        if (b.ff_full) bad_b++;
        if (acc_q.size() >= 3) begin
          w0 = acc_q.pop_front();
          w1 = acc_q.pop_front();
          w2 = acc_q.pop_front();
          exp_b = {w2, w1, w0};
          if (b.ff_wdata !== exp_b) bad_b++;
        end else begin
          bad_b++;
        end
      end
      if (done_b) done_cnt_b++;
      @(posedge clock);
      #1;
      b.s_valid = ($urandom_range(7) != 0);
      b.s_data  = cur;
      b.ff_full = ($urandom_range(7) == 0);
    end
    check("big_done_timeout", (t < 85000), 1);
    repeat (4) begin
      @(negedge clock);
      if (b.ff_wrreq) writes_b++;
      if (done_b) done_cnt_b++;
    end
    check("big_writes", writes_b, 12544);
    check("big_done_pulses", done_cnt_b, 1);
    check("big_pix_count", pc_b, 12544);
    check("big_data_errors", bad_b, 0);
    check("big_leftover_words", acc_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vip_featuremap_pack3_writer.md
VIP_FEATUREMAP_PACK3_WRITER -- requirements
Module: vip_featuremap_pack3_writer

Interface
REQ-001 Parameters SHALL be: DWIDTH, default 32, channel word width; NPIX, default 12544, pixels per frame (112x112).
REQ-002 Port clock  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 Port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 Port start  input  1  one-cycle frame-start pulse.
REQ-005 Port s_data  input  DWIDTH  one channel word from the upstream stream.
REQ-006 Port s_valid  input  1  s_data is valid.
REQ-007 Port s_ready  output  1  block accepts s_data this cycle.
REQ-008 Port ff_wdata  output  3*DWIDTH  packed 3-channel pixel for the conv2d input FIFO.
REQ-009 Port ff_wrreq  output  1  FIFO write strobe.
REQ-010 Port ff_full  input  1  downstream FIFO full.
REQ-011 Port busy  output  1  frame in progress.
REQ-012 Port done  output  1  one-cycle pulse at frame end.
REQ-013 Port pix_count  output  14  pixels written in the current frame.

Function
REQ-014 The FSM SHALL have states IDLE, COLLECT, PUSH and DONE.
REQ-015 In IDLE, start=1 SHALL clear pix_count and the channel index and move to COLLECT on the next edge; start SHALL be ignored in every other state.
REQ-016 s_ready SHALL be 1 only in COLLECT; a word transfers when s_valid=1 and s_ready=1.
REQ-017 Channel index 0,1,2 SHALL store the word into ff_wdata[DWIDTH-1:0], [2*DWIDTH-1:DWIDTH] and [3*DWIDTH-1:2*DWIDTH] respectively, then increment.
REQ-018 On the transfer of channel 2, the index SHALL wrap to 0 and the FSM SHALL move to PUSH.
REQ-019 In PUSH, ff_wrreq SHALL equal NOT ff_full (combinational); ff_wdata SHALL stay stable for the whole of PUSH.
REQ-020 While ff_full=1 in PUSH, the FSM SHALL hold with ff_wrreq=0 and no data loss, for any number of cycles.
REQ-021 On a PUSH cycle with ff_wrreq=1, pix_count SHALL increment.
REQ-022 On that cycle, the FSM SHALL move to DONE if pix_count was NPIX-1, otherwise to COLLECT.
REQ-023 Each written pixel SHALL be exactly one ff_wrreq cycle; ff_wrreq SHALL never be 1 outside PUSH or while ff_full=1.
REQ-024 Minimum pixel period SHALL be 4 cycles: 3 accept cycles plus 1 push cycle.
REQ-025 In DONE, done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE; pix_count SHALL hold NPIX until the next start.
REQ-026 busy SHALL be 1 in COLLECT and PUSH, and 0 in IDLE and DONE.
REQ-027 s_valid toggling mid-pixel SHALL only stall accumulation; partial channels SHALL be retained.

Reset
REQ-028 While reset=0, the state SHALL be IDLE and s_ready, ff_wrreq, busy, done, pix_count, the channel index and ff_wdata SHALL all be 0, regardless of clock.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no further ff_wrreq; after release the block SHALL wait in IDLE for start.

Verification
REQ-030 NPIX=4, start, then words 1..12 with s_valid constant and ff_full=0 -> 4 writes: 0x00000003_00000002_00000001, ..., 0x0000000C_0000000B_0000000A; done exactly 16 cycles after the first accept.
REQ-031 ff_full=1 for 5 cycles during the first PUSH -> ff_wrreq=0 and ff_wdata stable for those 5 cycles; one write when ff_full drops; pix_count=1.
REQ-032 s_valid gaps of 2 cycles between words -> identical packed data to REQ-030; no extra or missing writes.
REQ-033 start pulsed while busy after pixel 2 -> ignored; frame completes with pix_count=4 and one done pulse.
REQ-034 reset=0 after 7 words, then release, then start, then 12 words -> no write from the aborted frame; the new frame packs correctly from channel 0.
REQ-035 Default NPIX=12544 run with random s_valid and ff_full -> exactly 12544 writes; done asserted once; pix_count=12544.
